// File: rtl/flag_unit_if.sv
// rtl/flag_unit_if.sv - ALU-side and issue-side signal bundle for flag_unit
interface flag_unit_if #(
  parameter int WIDTH       = 32,
  parameter int STACK_DEPTH = 4
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic             valid;
  logic             s;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH:0]   result;
  logic [3:0]       cond;
  logic             push;
  logic             pop;
  logic [3:0]       flags;
  logic             cond_pass;
  logic [DW-1:0]    stack_depth;
  logic             stack_err;

  modport master (
    output valid, s, opcode, in1, in2, result, cond, push, pop,
    input  flags, cond_pass, stack_depth, stack_err
  );

  modport slave (
    input  valid, s, opcode, in1, in2, result, cond, push, pop,
    output flags, cond_pass, stack_depth, stack_err
  );
endinterface

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - registered NZCV flags, condition evaluation and flag save/restore stack
module flag_unit #(
  parameter int WIDTH       = 32,
  parameter int STACK_DEPTH = 4,
  parameter bit SUB_BORROW  = 1'b0,
  parameter bit FORWARD     = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  flag_unit_if.slave io_fu
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  logic [3:0]    r_flags;
  logic [DW-1:0] r_depth;
  logic          r_err;
  logic [3:0]    r_stack [2**AW];

  logic          w_is_add;
  logic          w_is_sub;
  logic          w_upd;
  logic          w_a_msb;
  logic          w_b_msb;
  logic          w_r_msb;
  logic          w_v;
  logic [3:0]    w_upd_flags;
  logic [3:0]    w_flags_next;
  logic [3:0]    w_src;
  logic          w_pass;
  logic          w_push_only;
  logic          w_pop_only;
  logic          w_full;
  logic          w_empty;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_err_next;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_unused_ok;

  assign w_is_add = (io_fu.opcode == 4'b0000);
  assign w_is_sub = (io_fu.opcode == 4'b0001) || (io_fu.opcode == 4'b1011);
  assign w_upd    = io_fu.valid && (io_fu.opcode != 4'b1111) &&
                    (io_fu.s || (io_fu.opcode == 4'b1011));

  assign w_a_msb = io_fu.in1[WIDTH-1];
  assign w_b_msb = io_fu.in2[WIDTH-1];
  assign w_r_msb = io_fu.result[WIDTH-1];
  // Only the operand sign bits matter for overflow detection
  assign w_unused_ok = ^{io_fu.in1[WIDTH-2:0], io_fu.in2[WIDTH-2:0]};

  always_comb begin
    w_v = r_flags[0];
    if (w_is_add) begin
      w_v = (w_a_msb == w_b_msb) && (w_r_msb != w_a_msb);
    end else if (w_is_sub) begin
      w_v = (w_a_msb != w_b_msb) && (w_r_msb != w_a_msb);
    end
  end

  assign w_upd_flags = {w_r_msb,
                        (io_fu.result[WIDTH-1:0] == '0),
                        io_fu.result[WIDTH] ^ (SUB_BORROW && w_is_sub),
                        w_v};

  // Simultaneous push and pop cancel out: neither touches the stack
  assign w_push_only = io_fu.push && !io_fu.pop;
  assign w_pop_only  = io_fu.pop && !io_fu.push;
  assign w_full      = (r_depth == FULL);
  assign w_empty     = (r_depth == '0);
  assign w_push_ok   = w_push_only && !w_full;
  assign w_pop_ok    = w_pop_only && !w_empty;
  assign w_err_next  = (w_push_only && w_full) || (w_pop_only && w_empty);
  assign w_wr_idx    = AW'(r_depth);
  assign w_rd_idx    = AW'(r_depth - DW'(1));

  always_comb begin
    w_flags_next = r_flags;
    if (w_pop_ok) begin
      w_flags_next = r_stack[w_rd_idx];
    end else if (w_upd) begin
      w_flags_next = w_upd_flags;
    end
  end

  assign w_src = FORWARD ? w_flags_next : r_flags;

  always_comb begin
    w_pass = 1'b0;
    case (io_fu.cond)
      4'b0000: w_pass = w_src[2];
      4'b0001: w_pass = !w_src[2];
      4'b0010: w_pass = w_src[1];
      4'b0011: w_pass = !w_src[1];
      4'b0100: w_pass = w_src[3];
      4'b0101: w_pass = !w_src[3];
      4'b0110: w_pass = w_src[0];
      4'b0111: w_pass = !w_src[0];
      4'b1000: w_pass = w_src[1] && !w_src[2];
      4'b1001: w_pass = !w_src[1] || w_src[2];
      4'b1010: w_pass = (w_src[3] == w_src[0]);
      4'b1011: w_pass = (w_src[3] != w_src[0]);
      4'b1100: w_pass = !w_src[2] && (w_src[3] == w_src[0]);
      4'b1101: w_pass = w_src[2] || (w_src[3] != w_src[0]);
      4'b1110: w_pass = 1'b1;
      default: w_pass = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flags <= 4'b0000;
      r_depth <= '0;
      r_err   <= 1'b0;
    end else begin
      r_flags <= w_flags_next;
      r_err   <= w_err_next;
      if (w_push_ok) begin
        r_depth <= r_depth + DW'(1);
      end else if (w_pop_ok) begin
        r_depth <= r_depth - DW'(1);
      end
    end
  end

  // Stack contents need no reset; depth alone defines which entries are live
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_stack[w_wr_idx] <= r_flags;
    end
  end

  assign io_fu.flags       = r_flags;
  assign io_fu.cond_pass   = w_pass;
  assign io_fu.stack_depth = r_depth;
  assign io_fu.stack_err   = r_err;
endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - self-checking bench for flag_unit (two parameter sets side by side)
module tb_flag_unit;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  flag_unit_if #(.WIDTH(32), .STACK_DEPTH(4)) if0 ();
  flag_unit_if #(.WIDTH(32), .STACK_DEPTH(4)) if1 ();

  flag_unit #(.WIDTH(32), .STACK_DEPTH(4), .SUB_BORROW(1'b0), .FORWARD(1'b1)) u0 (
    .i_clk(clk), .i_rst(rst), .io_fu(if0)
  );
  flag_unit #(.WIDTH(32), .STACK_DEPTH(4), .SUB_BORROW(1'b1), .FORWARD(1'b0)) u1 (
    .i_clk(clk), .i_rst(rst), .io_fu(if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ctl = {valid, S, push, pop}; ef = {flags u0, flags u1}; ep = {pass u0, pass u1}
  typedef struct {
    logic [3:0]  ctl;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] r;
    logic [3:0]  cond;
    logic [7:0]  ef;
    logic [1:0]  ep;
    logic [2:0]  ed;
    logic        ee;
  } vec_t;

  vec_t tab[19];

  logic [3:0] mf0, mf1;
  logic [3:0] mq0[$];
  logic [3:0] mq1[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [32:0] r, input logic [3:0] cond);
    if0.valid = ctl[3]; if0.s = ctl[2]; if0.push = ctl[1]; if0.pop = ctl[0];
    if0.opcode = op; if0.in1 = a; if0.in2 = b; if0.result = r; if0.cond = cond;
    if1.valid = ctl[3]; if1.s = ctl[2]; if1.push = ctl[1]; if1.pop = ctl[0];
    if1.opcode = op; if1.in1 = a; if1.in2 = b; if1.result = r; if1.cond = cond;
  endtask

  task automatic check_state(input string nm, input logic [7:0] ef, input logic [2:0] ed, input logic ee);
    check({nm, ".flags0"}, 32'(if0.flags), 32'(ef[7:4]));
    check({nm, ".flags1"}, 32'(if1.flags), 32'(ef[3:0]));
    check({nm, ".depth0"}, 32'(if0.stack_depth), 32'(ed));
    check({nm, ".depth1"}, 32'(if1.stack_depth), 32'(ed));
    check({nm, ".err0"}, 32'(if0.stack_err), 32'(ee));
    check({nm, ".err1"}, 32'(if1.stack_err), 32'(ee));
  endtask

  // Called at posedge+1; checks cond_pass mid-cycle, registered state after the edge
  task automatic step(input string nm, input logic [3:0] ctl, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [32:0] r,
                      input logic [3:0] cond, input logic [7:0] ef, input logic [1:0] ep,
                      input logic [2:0] ed, input logic ee);
    drive(ctl, op, a, b, r, cond);
    @(negedge clk);
    check({nm, ".pass0"}, 32'(if0.cond_pass), 32'(ep[1]));
    check({nm, ".pass1"}, 32'(if1.cond_pass), 32'(ep[0]));
    @(posedge clk);
    #1;
    check_state(nm, ef, ed, ee);
  endtask

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Flags from the arithmetic meaning of the operation rather than from result bits
  function automatic logic [3:0] model_upd(input bit borrow, input logic [3:0] old, input logic [3:0] op,
                                           input logic [31:0] a, input logic [31:0] b, input logic [32:0] r);
    longint sa, sb, s;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = r[32];
    v = old[0];
    if (op == 4'h0) begin
      s = sa + sb;
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      c = (({32'b0, a} + {32'b0, b}) >= 64'h1_0000_0000);
    end else if (op == 4'h1 || op == 4'hB) begin
      s = sa - sb;
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      c = (a >= b) ^ borrow;
    end
    return {r[31], (r[31:0] == 32'h0), c, v};
  endfunction

  task automatic do_reset;
    drive(4'b0000, 4'hF, 32'h0, 32'h0, 33'h0, 4'hE);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mf0 = 4'h0;
    mf1 = 4'h0;
    mq0.delete();
    mq1.delete();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    drive(4'b0000, 4'hF, 32'h0, 32'h0, 33'h0, 4'hE);

    tab[0]  = '{4'b1100, 4'h0, 32'h7FFFFFFF, 32'h1, 33'h0_80000000, 4'hB, 8'h99, 2'b00, 3'd0, 1'b0};
    tab[1]  = '{4'b1100, 4'h2, 32'h0, 32'h0, 33'h0_00000000, 4'h0, 8'h55, 2'b10, 3'd0, 1'b0};
    tab[2]  = '{4'b1000, 4'hB, 32'h5, 32'h5, 33'h1_00000000, 4'h0, 8'h64, 2'b11, 3'd0, 1'b0};
    tab[3]  = '{4'b1000, 4'h1, 32'h1, 32'h2, 33'h1_FFFFFFFF, 4'h1, 8'h64, 2'b00, 3'd0, 1'b0};
    tab[4]  = '{4'b1100, 4'hF, 32'h0, 32'h0, 33'h1_80000000, 4'h2, 8'h64, 2'b10, 3'd0, 1'b0};
    tab[5]  = '{4'b0100, 4'h0, 32'h1, 32'h1, 33'h0_00000002, 4'hE, 8'h64, 2'b11, 3'd0, 1'b0};
    tab[6]  = '{4'b1100, 4'h2, 32'h0, 32'h0, 33'h0_80000000, 4'h4, 8'h88, 2'b10, 3'd0, 1'b0};
    tab[7]  = '{4'b0010, 4'h0, 32'h0, 32'h0, 33'h0, 4'hE, 8'h88, 2'b11, 3'd1, 1'b0};
    tab[8]  = '{4'b1000, 4'hB, 32'h5, 32'h5, 33'h1_00000000, 4'h0, 8'h64, 2'b10, 3'd1, 1'b0};
    tab[9]  = '{4'b1101, 4'h0, 32'h1, 32'h1, 33'h0_00000002, 4'h4, 8'h88, 2'b10, 3'd0, 1'b0};
    tab[10] = '{4'b0001, 4'h0, 32'h0, 32'h0, 33'h0, 4'hF, 8'h88, 2'b00, 3'd0, 1'b1};
    tab[11] = '{4'b0000, 4'h0, 32'h0, 32'h0, 33'h0, 4'h5, 8'h88, 2'b00, 3'd0, 1'b0};
    tab[12] = '{4'b1101, 4'h0, 32'h1, 32'h1, 33'h0_00000002, 4'h0, 8'h00, 2'b00, 3'd0, 1'b1};
    tab[13] = '{4'b0000, 4'h0, 32'h0, 32'h0, 33'h0, 4'h0, 8'h00, 2'b00, 3'd0, 1'b0};
    tab[14] = '{4'b0010, 4'h0, 32'h0, 32'h0, 33'h0, 4'hE, 8'h00, 2'b11, 3'd1, 1'b0};
    tab[15] = '{4'b0010, 4'h0, 32'h0, 32'h0, 33'h0, 4'hE, 8'h00, 2'b11, 3'd2, 1'b0};
    tab[16] = '{4'b1011, 4'hB, 32'h5, 32'h5, 33'h1_00000000, 4'h3, 8'h64, 2'b01, 3'd2, 1'b0};
    tab[17] = '{4'b0001, 4'h0, 32'h0, 32'h0, 33'h0, 4'hE, 8'h00, 2'b11, 3'd1, 1'b0};
    tab[18] = '{4'b0001, 4'h0, 32'h0, 32'h0, 33'h0, 4'h0, 8'h00, 2'b00, 3'd0, 1'b0};

    #12;
    check_state("reset", 8'h00, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step($sformatf("vec%0d", i), tab[i].ctl, tab[i].op, tab[i].a, tab[i].b, tab[i].r,
           tab[i].cond, tab[i].ef, tab[i].ep, tab[i].ed, tab[i].ee);
    end

    for (int i = 1; i <= 5; i++) begin
      step($sformatf("ovf_push%0d", i), 4'b0010, 4'h0, 32'h0, 32'h0, 33'h0, 4'hE, 8'h00, 2'b11,
           (i > 4) ? 3'd4 : 3'(i), (i == 5));
    end
    step("ovf_idle", 4'b0000, 4'h0, 32'h0, 32'h0, 33'h0, 4'hE, 8'h00, 2'b11, 3'd4, 1'b0);

    do_reset();
    step("rst_add", 4'b1100, 4'h0, 32'h7FFFFFFF, 32'h1, 33'h0_80000000, 4'hE, 8'h99, 2'b11, 3'd0, 1'b0);
    step("rst_push1", 4'b0010, 4'h0, 32'h0, 32'h0, 33'h0, 4'hE, 8'h99, 2'b11, 3'd1, 1'b0);
    step("rst_push2", 4'b0010, 4'h0, 32'h0, 32'h0, 33'h0, 4'hE, 8'h99, 2'b11, 3'd2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_state("async_rst", 8'h00, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  ctl, op, cond, n0, n1;
      logic [31:0] a, b;
      logic [32:0] r;
      logic        upd, e, p0, p1;
      int          sel;
      ctl = {($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0};
      sel = int'($urandom_range(0, 5));
      op = (sel == 0) ? 4'h0 : (sel == 1) ? 4'h1 : (sel == 2) ? 4'hB : (sel == 3) ? 4'hF : 4'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      cond = 4'($urandom);
      if (op == 4'h0) r = {1'b0, a} + {1'b0, b};
      else if (op == 4'h1 || op == 4'hB) r = {1'b0, a} + {1'b0, ~b} + 33'd1;
      else r = ($urandom_range(0, 3) == 0) ? {1'($urandom), 32'h0} : {1'($urandom), $urandom};

      upd = ctl[3] && (op != 4'hF) && (ctl[2] || op == 4'hB);
      n0 = upd ? model_upd(1'b0, mf0, op, a, b, r) : mf0;
      n1 = upd ? model_upd(1'b1, mf1, op, a, b, r) : mf1;
      e = 1'b0;
      if (ctl[1] && !ctl[0]) begin
        if (mq0.size() < 4) begin
          mq0.push_back(mf0);
          mq1.push_back(mf1);
        end else e = 1'b1;
      end else if (ctl[0] && !ctl[1]) begin
        if (mq0.size() > 0) begin
          n0 = mq0.pop_back();
          n1 = mq1.pop_back();
        end else e = 1'b1;
      end
      p0 = cond_eval(cond, n0);
      p1 = cond_eval(cond, mf1);
      mf0 = n0;
      mf1 = n1;
      step($sformatf("rnd%0d", i), ctl, op, a, b, r, cond, {n0, n1}, {p0, p1},
           3'(mq0.size()), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
